// File: rtl/keccak_feed_pkg.sv
// Shared types and helpers for the masked Keccak absorb feeder.
//
// Contents:
//   FeedState_t  - feeder FSM encoding (IDLE, FEED, SQUEEZE; 2'b11 reserved)
//   DEF_*        - default configuration (RATE=1088, W=64, SHARES=2,
//                  ABSORB_LANES=RATE/W, ABSORB_SLICES=1)
//   NUM_LANES    - lanes per rate block for the default configuration
//   NUM_CHUNKS   - absorb chunks per block for the default configuration
//   Chunk_t      - one absorb chunk, packed [share][slot][slice]
//   idx_width()  - counter/index width that never collapses to zero bits
package keccak_feed_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FEED    = 2'd1,
    SQUEEZE = 2'd2
  } FeedState_t;

  localparam int DEF_RATE          = 1088;
  localparam int DEF_W             = 64;
  localparam int DEF_SHARES        = 2;
  localparam int DEF_ABSORB_LANES  = DEF_RATE / DEF_W;
  localparam int DEF_ABSORB_SLICES = 1;

  localparam int NUM_LANES  = DEF_RATE / DEF_W;
  localparam int NUM_CHUNKS = (NUM_LANES / DEF_ABSORB_LANES) * (DEF_W / DEF_ABSORB_SLICES);

  typedef logic [DEF_SHARES-1:0][DEF_ABSORB_LANES-1:0][DEF_ABSORB_SLICES-1:0] Chunk_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keccak_feed_chunk_sel.sv
// Combinational chunk selector for one share of the stored block.
//
// Ports:
//   ShareBlockxDI  in  RATE                        one share of the block, lane l at [l*W +: W]
//   LaneBasexDI    in  idx_width(RATE/W)           first lane of the current lane group
//   SliceBasexDI   in  idx_width(W)                first slice of the current slice group
//   ChunkxDO       out ABSORB_LANES*ABSORB_SLICES  packed [slot][slice]
//
// LaneBase is always a multiple of ABSORB_LANES, so slot (LaneBase+j)%ABSORB_LANES
// reduces to slot j.
module keccak_feed_chunk_sel
  import keccak_feed_pkg::*;
#(
  parameter int RATE          = 1088,
  parameter int W             = 64,
  parameter int ABSORB_LANES  = RATE / W,
  parameter int ABSORB_SLICES = 1
) (
  input  logic [RATE-1:0]                         ShareBlockxDI,
  input  logic [idx_width(RATE/W)-1:0]            LaneBasexDI,
  input  logic [idx_width(W)-1:0]                 SliceBasexDI,
  output logic [ABSORB_LANES*ABSORB_SLICES-1:0]   ChunkxDO
);

  localparam int LaneCnt = RATE / W;
  localparam int LbW     = idx_width(LaneCnt);
  localparam int SbW     = idx_width(W);

  logic [LaneCnt-1:0][W-1:0] LanesxD;

  assign LanesxD = ShareBlockxDI;

  for (genvar j = 0; j < ABSORB_LANES; j++) begin : g_slot
    logic [LbW-1:0] LaneIdxxD;
    logic [W-1:0]   LaneWordxD;

    assign LaneIdxxD  = LaneBasexDI + LbW'(j);
    assign LaneWordxD = LanesxD[LaneIdxxD];

    for (genvar k = 0; k < ABSORB_SLICES; k++) begin : g_slice
      assign ChunkxDO[j*ABSORB_SLICES + k] = LaneWordxD[SliceBasexDI + SbW'(k)];
    end
  end

endmodule

// File: rtl/keccak_absorb_feeder.sv
// Masked message feeder: takes one rate block as SHARES Boolean shares and
// serializes it into lane-group/slice-chunk words on the Keccak core's absorb
// port, then raises the squeeze request after a final block.
//
// Ports:
//   ClkxCI           in   clock, rising edge
//   RstxRI           in   asynchronous active-high reset
//   BlockValidxSI    in   input block valid (only looked at in IDLE)
//   BlockReadyxSO    out  feeder can accept a block (IDLE, not in reset)
//   LastBlockxSI     in   sampled with the block; squeeze after it
//   BlockxDI         in   SHARES*RATE, share s at [s*RATE +: RATE]
//   StartAbsorbxSO   out  chunk on AbsorbSlicesxDO valid
//   AbsorbSlicesxDO  out  SHARES*ABSORB_LANES*ABSORB_SLICES, packed [share][slot][slice]
//   CoreReadyxSI     in   core accepts the chunk or the squeeze request
//   StartSqueezexSO  out  squeeze request
//   BusyxSO          out  state != IDLE
//   DbgStatexDO      out  raw FSM state
//
// Handshake: a transfer happens on a rising edge where the sender's valid
// (BlockValidxSI/BlockReadyxSO on input, StartAbsorbxSO or StartSqueezexSO vs
// CoreReadyxSI on output) and the receiver's ready are both high. While valid
// is high and ready low, the offered data stays unchanged.
//
// Optional build macro KECCAK_FEED_SCRUB_EN: wipes the block register after the
// final chunk is taken and forces AbsorbSlicesxDO to 0 while StartAbsorbxSO=0.
module keccak_absorb_feeder
  import keccak_feed_pkg::*;
#(
  parameter int RATE          = 1088,
  parameter int W             = 64,
  parameter int SHARES        = 2,
  parameter int ABSORB_LANES  = RATE / W,
  parameter int ABSORB_SLICES = 1
) (
  input  logic                                          ClkxCI,
  input  logic                                          RstxRI,
  input  logic                                          BlockValidxSI,
  output logic                                          BlockReadyxSO,
  input  logic                                          LastBlockxSI,
  input  logic [SHARES*RATE-1:0]                        BlockxDI,
  output logic                                          StartAbsorbxSO,
  output logic [SHARES*ABSORB_LANES*ABSORB_SLICES-1:0]  AbsorbSlicesxDO,
  input  logic                                          CoreReadyxSI,
  output logic                                          StartSqueezexSO,
  output logic                                          BusyxSO,
  output logic [1:0]                                    DbgStatexDO
);

  localparam int LaneCnt = RATE / W;
  localparam int LbW     = idx_width(LaneCnt);
  localparam int SbW     = idx_width(W);
  localparam int ChunkW  = ABSORB_LANES * ABSORB_SLICES;

  localparam logic [LbW-1:0] LaneLast  = LbW'(LaneCnt - ABSORB_LANES);
  localparam logic [LbW-1:0] LaneStep  = LbW'(ABSORB_LANES);
  localparam logic [SbW-1:0] SliceLast = SbW'(W - ABSORB_SLICES);
  localparam logic [SbW-1:0] SliceStep = SbW'(ABSORB_SLICES);

  if ((RATE % W) != 0) begin : g_chk_rate
    $error("RATE must be a multiple of W");
  end
  if ((LaneCnt % ABSORB_LANES) != 0) begin : g_chk_lanes
    $error("ABSORB_LANES must divide RATE/W");
  end
  if ((W % ABSORB_SLICES) != 0) begin : g_chk_slices
    $error("ABSORB_SLICES must divide W");
  end

  FeedState_t                 StatexDP;
  logic [SHARES*RATE-1:0]     BlockxDP;
  logic                       LastxDP;
  logic [LbW-1:0]             LaneBasexDP;
  logic [SbW-1:0]             SliceBasexDP;
  logic [SHARES*ChunkW-1:0]   ChunkMuxxD;
  logic                       FinalChunkxS;

  // Each share has its own selector so share bits never meet in one mux.
  for (genvar s = 0; s < SHARES; s++) begin : g_share
    keccak_feed_chunk_sel #(
      .RATE          (RATE),
      .W             (W),
      .ABSORB_LANES  (ABSORB_LANES),
      .ABSORB_SLICES (ABSORB_SLICES)
    ) u_sel (
      .ShareBlockxDI (BlockxDP[s*RATE +: RATE]),
      .LaneBasexDI   (LaneBasexDP),
      .SliceBasexDI  (SliceBasexDP),
      .ChunkxDO      (ChunkMuxxD[s*ChunkW +: ChunkW])
    );
  end

  assign FinalChunkxS = (LaneBasexDP == LaneLast) && (SliceBasexDP == SliceLast);

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      StatexDP     <= IDLE;
      BlockxDP     <= '0;
      LastxDP      <= 1'b0;
      LaneBasexDP  <= '0;
      SliceBasexDP <= '0;
    end else begin
      case (StatexDP)
        IDLE: begin
          if (BlockValidxSI) begin
            BlockxDP     <= BlockxDI;
            LastxDP      <= LastBlockxSI;
            LaneBasexDP  <= '0;
            SliceBasexDP <= '0;
            StatexDP     <= FEED;
          end
        end
        FEED: begin
          if (CoreReadyxSI) begin
            // Slices are the inner loop, lane groups the outer loop.
            if (SliceBasexDP == SliceLast) begin
              SliceBasexDP <= '0;
              if (FinalChunkxS) begin
                LaneBasexDP <= '0;
                StatexDP    <= LastxDP ? SQUEEZE : IDLE;
`ifdef KECCAK_FEED_SCRUB_EN
                BlockxDP    <= '0;
`endif
              end else begin
                LaneBasexDP <= LaneBasexDP + LaneStep;
              end
            end else begin
              SliceBasexDP <= SliceBasexDP + SliceStep;
            end
          end
        end
        SQUEEZE: begin
          if (CoreReadyxSI) begin
            StatexDP <= IDLE;
          end
        end
        default: StatexDP <= IDLE;
      endcase
    end
  end

  // BlockReady is gated by reset so it reads 0 for the whole reset pulse.
  assign BlockReadyxSO   = (StatexDP == IDLE) && !RstxRI;
  assign StartAbsorbxSO  = (StatexDP == FEED);
  assign StartSqueezexSO = (StatexDP == SQUEEZE);
  assign BusyxSO         = (StatexDP != IDLE);
  assign DbgStatexDO     = StatexDP;

`ifdef KECCAK_FEED_SCRUB_EN
  assign AbsorbSlicesxDO = StartAbsorbxSO ? ChunkMuxxD : '0;
`else
  assign AbsorbSlicesxDO = ChunkMuxxD;
`endif

endmodule

// File: tb/tb_keccak_absorb_feeder.sv
module tb_keccak_absorb_feeder;
  import keccak_feed_pkg::*;

  localparam int RATE   = 1088;
  localparam int W      = 64;
  localparam int SHARES = 2;
  localparam int AL     = 17;
  localparam int AS     = 1;
  localparam int SW     = AL * AS;
  localparam int CW     = SHARES * SW;
  localparam int BW1    = SHARES * RATE;

  localparam int RATE2  = 1344;
  localparam int AL2    = 7;
  localparam int AS2    = 4;
  localparam int CW2    = SHARES * AL2 * AS2;
  localparam int BW     = SHARES * RATE2;

  logic ClkxCI = 1'b0;
  logic RstxRI = 1'b1;

  logic           BlockValidxS = 1'b0;
  logic           BlockReadyxS;
  logic           LastBlockxS = 1'b0;
  logic [BW1-1:0] BlockxD = '0;
  logic           StartAbsorbxS;
  logic [CW-1:0]  AbsorbxD;
  logic           CoreReadyxS = 1'b0;
  logic           StartSqueezexS;
  logic           BusyxS;
  logic [1:0]     DbgStatexD;

  logic           BlockValid2xS = 1'b0;
  logic           BlockReady2xS;
  logic           LastBlock2xS = 1'b0;
  logic [BW-1:0]  Block2xD = '0;
  logic           StartAbsorb2xS;
  logic [CW2-1:0] Absorb2xD;
  logic           CoreReady2xS = 1'b0;
  logic           StartSqueeze2xS;
  logic           Busy2xS;
  logic [1:0]     DbgState2xD;

  int checks = 0;
  int errors = 0;

  always #5 ClkxCI = ~ClkxCI;

  keccak_absorb_feeder #(
    .RATE(RATE), .W(W), .SHARES(SHARES), .ABSORB_LANES(AL), .ABSORB_SLICES(AS)
  ) u_dut (
    .ClkxCI          (ClkxCI),
    .RstxRI          (RstxRI),
    .BlockValidxSI   (BlockValidxS),
    .BlockReadyxSO   (BlockReadyxS),
    .LastBlockxSI    (LastBlockxS),
    .BlockxDI        (BlockxD),
    .StartAbsorbxSO  (StartAbsorbxS),
    .AbsorbSlicesxDO (AbsorbxD),
    .CoreReadyxSI    (CoreReadyxS),
    .StartSqueezexSO (StartSqueezexS),
    .BusyxSO         (BusyxS),
    .DbgStatexDO     (DbgStatexD)
  );

  keccak_absorb_feeder #(
    .RATE(RATE2), .W(W), .SHARES(SHARES), .ABSORB_LANES(AL2), .ABSORB_SLICES(AS2)
  ) u_alt (
    .ClkxCI          (ClkxCI),
    .RstxRI          (RstxRI),
    .BlockValidxSI   (BlockValid2xS),
    .BlockReadyxSO   (BlockReady2xS),
    .LastBlockxSI    (LastBlock2xS),
    .BlockxDI        (Block2xD),
    .StartAbsorbxSO  (StartAbsorb2xS),
    .AbsorbSlicesxDO (Absorb2xD),
    .CoreReadyxSI    (CoreReady2xS),
    .StartSqueezexSO (StartSqueeze2xS),
    .BusyxSO         (Busy2xS),
    .DbgStatexDO     (DbgState2xD)
  );

  // Reference chunk c: lane group c/(W/asl), slice group c%(W/asl);
  // result bit (s*al+j)*asl+k = share s, lane lg*al+j, bit sg*asl+k.
  function automatic logic [63:0] exp_chunk(input logic [BW-1:0] blk, input int rate,
                                            input int al, input int asl, input int c);
    logic [63:0]   r;
    logic [BW-1:0] t;
    int spc, lg, sg;
    r   = '0;
    spc = W / asl;
    lg  = c / spc;
    sg  = c % spc;
    for (int s = 0; s < SHARES; s++)
      for (int j = 0; j < al; j++)
        for (int k = 0; k < asl; k++) begin
          t = blk >> (s*rate + (lg*al + j)*W + sg*asl + k);
          r = r | (64'(t[0]) << ((s*al + j)*asl + k));
        end
    return r;
  endfunction

  function automatic logic [BW1-1:0] rand_block();
    logic [BW1-1:0] r;
    r = '0;
    for (int i = 0; i < BW1/32; i++) r = (r << 32) | BW1'($urandom());
    return r;
  endfunction

  // Driver: offer one block on the default DUT; returns at the negedge where
  // chunk 0 should be on the bus.
  task automatic send_block(input logic [BW1-1:0] b, input logic last);
    int n;
    n = 0;
    @(negedge ClkxCI);
    while (!BlockReadyxS && n < 50) begin
      @(negedge ClkxCI);
      n++;
    end
    checks++;
    if (BlockReadyxS !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: BlockReady=%b required 1", BlockReadyxS);
    end
    BlockxD      = b;
    LastBlockxS  = last;
    BlockValidxS = 1'b1;
    @(negedge ClkxCI);
    BlockValidxS = 1'b0;
    LastBlockxS  = 1'b0;
    checks++;
    if (StartAbsorbxS !== 1'b1) begin
      errors++;
      $display("FAIL first_absorb: StartAbsorb=%b required 1", StartAbsorbxS);
    end
  endtask

  task automatic test_reset;
    RstxRI = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ClkxCI);
      checks++;
      if ({BlockReadyxS, StartAbsorbxS, StartSqueezexS, BusyxS} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ctrl: {rdy,abs,sqz,busy}=%b required 0000",
                 {BlockReadyxS, StartAbsorbxS, StartSqueezexS, BusyxS});
      end
      checks++;
      if (AbsorbxD !== '0) begin
        errors++;
        $display("FAIL reset_data: Absorb=%h required 0", AbsorbxD);
      end
    end
    checks++;
    if ({BlockReady2xS, StartAbsorb2xS, StartSqueeze2xS, Busy2xS} !== 4'b0000 || Absorb2xD !== '0) begin
      errors++;
      $display("FAIL reset_alt: ctrl=%b data=%h required 0",
               {BlockReady2xS, StartAbsorb2xS, StartSqueeze2xS, Busy2xS}, Absorb2xD);
    end
    RstxRI = 1'b0;
    @(negedge ClkxCI);
    checks++;
    if (BlockReadyxS !== 1'b1 || BusyxS !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: rdy=%b busy=%b required 1/0", BlockReadyxS, BusyxS);
    end
    checks++;
    if (DbgStatexD !== IDLE || DbgState2xD !== IDLE) begin
      errors++;
      $display("FAIL post_reset_state: state=%0d alt=%0d required 0", DbgStatexD, DbgState2xD);
    end
  endtask

  task automatic test_single_bit;
    logic [BW1-1:0] b;
    logic [63:0]    e;
    int c;
    b = '0;
    b[63:0] = 64'h8000_0000_0000_0001;
    CoreReadyxS = 1'b1;
    send_block(b, 1'b0);
    checks++;
    if (DbgStatexD !== FEED) begin
      errors++;
      $display("FAIL feed_state: state=%0d required %0d", DbgStatexD, FEED);
    end
    c = 0;
    while (StartAbsorbxS && c < 200) begin
      e = exp_chunk(BW'(b), RATE, AL, AS, c);
      checks++;
      if (AbsorbxD !== e[CW-1:0]) begin
        errors++;
        $display("FAIL single_chunk %0d: got %h required %h", c, AbsorbxD, e[CW-1:0]);
      end
      checks++;
      if (AbsorbxD[0] !== ((c == 0) || (c == 63))) begin
        errors++;
        $display("FAIL single_slot0 %0d: got %b", c, AbsorbxD[0]);
      end
      c++;
      @(negedge ClkxCI);
    end
    CoreReadyxS = 1'b0;
    checks++;
    if (c != 64) begin
      errors++;
      $display("FAIL single_count: got %0d required 64", c);
    end
    checks++;
    if (BlockReadyxS !== 1'b1 || BusyxS !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: rdy=%b busy=%b required 1/0", BlockReadyxS, BusyxS);
    end
`ifdef KECCAK_FEED_SCRUB_EN
    e = '0;
`else
    e = exp_chunk(BW'(b), RATE, AL, AS, 0);
`endif
    checks++;
    if (AbsorbxD !== e[CW-1:0]) begin
      errors++;
      $display("FAIL single_after: got %h required %h", AbsorbxD, e[CW-1:0]);
    end
  endtask

  task automatic test_backpressure;
    logic [BW1-1:0] b;
    logic [63:0]    e;
    logic [CW-1:0]  prev;
    logic [SW-1:0]  xo, xe;
    logic           stalled;
    int acc, cyc;
    b = rand_block();
    CoreReadyxS = 1'b0;
    send_block(b, 1'b0);
    acc = 0; cyc = 0; stalled = 1'b0; prev = '0;
    while (StartAbsorbxS && cyc < 400) begin
      e = exp_chunk(BW'(b), RATE, AL, AS, acc);
      checks++;
      if (AbsorbxD !== e[CW-1:0]) begin
        errors++;
        $display("FAIL bp_chunk %0d: got %h required %h", acc, AbsorbxD, e[CW-1:0]);
      end
      xo = AbsorbxD[SW-1:0] ^ AbsorbxD[2*SW-1:SW];
      xe = e[SW-1:0] ^ e[2*SW-1:SW];
      checks++;
      if (xo !== xe) begin
        errors++;
        $display("FAIL bp_xor %0d: got %h required %h", acc, xo, xe);
      end
      if (stalled) begin
        checks++;
        if (AbsorbxD !== prev) begin
          errors++;
          $display("FAIL bp_stable %0d: got %h required %h", acc, AbsorbxD, prev);
        end
      end
      CoreReadyxS = (cyc % 3 == 2);
      if (CoreReadyxS) acc++;
      stalled = !CoreReadyxS;
      prev = AbsorbxD;
      cyc++;
      @(negedge ClkxCI);
    end
    CoreReadyxS = 1'b0;
    checks++;
    if (acc != 64) begin
      errors++;
      $display("FAIL bp_accepts: got %0d required 64", acc);
    end
    checks++;
    if (BlockReadyxS !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready: got %b required 1", BlockReadyxS);
    end
  endtask

  task automatic test_squeeze;
    logic [BW1-1:0] b;
    logic [63:0]    e;
    logic           prev_abs;
    int acc, sq, n;
    b = rand_block();
    CoreReadyxS = 1'b1;
    send_block(b, 1'b1);
    acc = 0; sq = 0; n = 0; prev_abs = 1'b0;
    while (n < 300) begin
      if (StartAbsorbxS) begin
        e = exp_chunk(BW'(b), RATE, AL, AS, acc);
        checks++;
        if (AbsorbxD !== e[CW-1:0] || StartSqueezexS !== 1'b0) begin
          errors++;
          $display("FAIL sq_chunk %0d: got %h sqz=%b required %h/0", acc, AbsorbxD, StartSqueezexS, e[CW-1:0]);
        end
        acc++;
        CoreReadyxS = 1'b1;
        prev_abs = 1'b1;
      end else if (StartSqueezexS) begin
        sq++;
        if (sq == 1) begin
          checks++;
          if (!(prev_abs && acc == 64)) begin
            errors++;
            $display("FAIL sq_rise: prev_abs=%b accepts=%0d required 1/64", prev_abs, acc);
          end
        end
        prev_abs = 1'b0;
        CoreReadyxS = (sq >= 6);
      end else begin
        break;
      end
      n++;
      @(negedge ClkxCI);
    end
    CoreReadyxS = 1'b0;
    checks++;
    if (sq != 6) begin
      errors++;
      $display("FAIL sq_len: got %0d required 6", sq);
    end
    checks++;
    if (BlockReadyxS !== 1'b1 || BusyxS !== 1'b0 || StartSqueezexS !== 1'b0) begin
      errors++;
      $display("FAIL sq_done: rdy=%b busy=%b sqz=%b required 1/0/0", BlockReadyxS, BusyxS, StartSqueezexS);
    end
  endtask

  task automatic test_reset_mid;
    logic [BW1-1:0] b;
    logic [63:0]    e;
    int acc, c;
    b = rand_block();
    CoreReadyxS = 1'b1;
    send_block(b, 1'b0);
    acc = 0;
    while (StartAbsorbxS && acc < 20) begin
      acc++;
      @(negedge ClkxCI);
    end
    e = exp_chunk(BW'(b), RATE, AL, AS, 20);
    checks++;
    if (AbsorbxD !== e[CW-1:0] || acc != 20) begin
      errors++;
      $display("FAIL mid_chunk20: got %h at %0d required %h", AbsorbxD, acc, e[CW-1:0]);
    end
    #1 RstxRI = 1'b1;
    #1;
    checks++;
    if ({BlockReadyxS, StartAbsorbxS, StartSqueezexS, BusyxS} !== 4'b0000 || AbsorbxD !== '0) begin
      errors++;
      $display("FAIL mid_reset: ctrl=%b data=%h required 0",
               {BlockReadyxS, StartAbsorbxS, StartSqueezexS, BusyxS}, AbsorbxD);
    end
    @(negedge ClkxCI);
    RstxRI = 1'b0;
    b = rand_block();
    send_block(b, 1'b0);
    c = 0;
    while (StartAbsorbxS && c < 200) begin
      e = exp_chunk(BW'(b), RATE, AL, AS, c);
      checks++;
      if (AbsorbxD !== e[CW-1:0]) begin
        errors++;
        $display("FAIL mid_restart %0d: got %h required %h", c, AbsorbxD, e[CW-1:0]);
      end
      c++;
      @(negedge ClkxCI);
    end
    CoreReadyxS = 1'b0;
    checks++;
    if (c != 64) begin
      errors++;
      $display("FAIL mid_count: got %0d required 64", c);
    end
  endtask

  task automatic test_alt_config;
    logic [BW-1:0] b;
    logic [63:0]   e;
    int c, n;
    b = (BW'(64'hA000_0000_0000_0000) << (20*W)) |
        (BW'(64'h5000_0000_0000_0000) << (RATE2 + 20*W)) |
        BW'(64'h0123_4567_89AB_CDEF);
    CoreReady2xS = 1'b1;
    n = 0;
    @(negedge ClkxCI);
    while (!BlockReady2xS && n < 50) begin
      @(negedge ClkxCI);
      n++;
    end
    Block2xD = b;
    BlockValid2xS = 1'b1;
    @(negedge ClkxCI);
    BlockValid2xS = 1'b0;
    c = 0;
    while (StartAbsorb2xS && c < 200) begin
      e = exp_chunk(b, RATE2, AL2, AS2, c);
      checks++;
      if (Absorb2xD !== e[CW2-1:0]) begin
        errors++;
        $display("FAIL alt_chunk %0d: got %h required %h", c, Absorb2xD, e[CW2-1:0]);
      end
      if (c == 47) begin
        checks++;
        if (Absorb2xD[27:24] !== 4'hA || Absorb2xD[55:52] !== 4'h5) begin
          errors++;
          $display("FAIL alt_slot6: share0=%h share1=%h required a/5", Absorb2xD[27:24], Absorb2xD[55:52]);
        end
      end
      c++;
      @(negedge ClkxCI);
    end
    CoreReady2xS = 1'b0;
    checks++;
    if (c != 48) begin
      errors++;
      $display("FAIL alt_count: got %0d required 48", c);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_bit();
    test_backpressure();
    test_squeeze();
    test_reset_mid();
    test_alt_config();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
